acc_spm_ram: RTL and testbench
==============================

// Module: acc_spm_ram
// PURPOSE
//  Word-addressed single-port scratchpad shared by the core and an accelerator.
//  Replaces whole-window mirroring with a sequenced stream engine:
//   - on start, streams NUM_CH operand windows to the accelerator (valid/ready);
//   - accepts WIN_WORDS result words back into the result window.
//  The core port always has priority; the engine uses only idle port cycles.
// PARAMETERS
//  ADDR_WIDTH  12   core byte-address width
//  DATA_WIDTH  32   word width, multiple of 8
//  NUM_WORDS   4096 capacity in bytes; words = NUM_WORDS/(DATA_WIDTH/8)
//  NUM_CH      2    operand channels (1..8)
//  WIN_WORDS   256  words per operand and result window
//  Elaboration assert: (NUM_CH+1)*WIN_WORDS <= words
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              synchronous reset, active-high
//  en_i        in   1              core access request
//  addr_i      in   ADDR_WIDTH     core byte address (word = addr_i[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)])
//  wdata_i     in   DATA_WIDTH     core write data
//  we_i        in   1              core write enable
//  be_i        in   DATA_WIDTH/8   core byte enables
//  rdata_o     out  DATA_WIDTH     core read data, 1-cycle latency
//  start_i     in   1              one-cycle pulse starting a transfer
//  busy_o      out  1              engine not IDLE
//  done_o      out  1              one-cycle pulse after the last result write
//  op_valid_o  out  1              operand word valid
//  op_ready_i  in   1              accelerator accepts operand
//  op_data_o   out  DATA_WIDTH     operand word
//  op_ch_o     out  $clog2(NUM_CH)+1  channel of the operand word
//  op_last_o   out  1              last word of the current channel
//  res_valid_i in   1              result word valid
//  res_ready_o out  1              result accepted this cycle
//  res_data_i  in   DATA_WIDTH     result word
// BEHAVIOUR
//  Layout
//   - channel c occupies words [c*WIN_WORDS, (c+1)*WIN_WORDS);
//   - result window occupies [NUM_CH*WIN_WORDS, (NUM_CH+1)*WIN_WORDS).
//  Reset
//   - FSM goes to IDLE; all outputs are 0; counters are cleared.
//   - Memory contents are NOT cleared.
//   - Reset mid-transfer abandons the transfer without pulsing done_o.
//  Core port (every cycle en_i=1)
//   - Writes update enabled bytes of word addr.
//   - rdata_o <= mem[addr] on the next edge (old data on a same-cycle write).
//   - Word addr >= words: the write is dropped and rdata_o <= 0.
//  Engine FSM: IDLE -> OP_RD -> OP_OUT -> ... -> RES -> DONE -> IDLE
//   - IDLE: start_i -> OP_RD with ch=0, idx=0. start_i is ignored when not IDLE.
//   - OP_RD: if en_i=0, issue a read of word ch*WIN_WORDS+idx and go to OP_OUT.
//     Otherwise stall in OP_RD.
//   - OP_OUT:
//     - op_valid_o=1; op_data_o, op_ch_o and op_last_o are held stable until op_ready_i.
//     - op_last_o = (idx==WIN_WORDS-1).
//     - On handshake:
//       - if idx<WIN_WORDS-1: idx++ -> OP_RD;
//       - else if ch<NUM_CH-1: ch++, idx=0 -> OP_RD;
//       - else idx=0 -> RES.
//   - RES:
//     - res_ready_o = ~en_i (combinational).
//     - On res_valid_i & res_ready_o: write the full word res_data_i to
//       NUM_CH*WIN_WORDS+idx, then idx++.
//     - The handshake at idx==WIN_WORDS-1 -> DONE.
//   - DONE: done_o=1 for one cycle -> IDLE.
//  Contention and timing
//   - The engine never touches memory in a cycle with en_i=1.
//   - Operand throughput is 1 word per 2 cycles without contention.
//   - Results are accepted 1 per cycle.
//   - A core write to an operand word before the engine's read issue is visible
//     in the stream; after issue it is not.
//   - Core reads of the result window during RES return data as of that cycle.
//  busy_o = (state != IDLE), registered.
//  Counters are $clog2(WIN_WORDS)+1 bits wide; no wrap beyond WIN_WORDS-1.
// STRUCTURE
//  acc_spm_pkg
//   - typedef enum logic [2:0] {IDLE, OP_RD, OP_OUT, RES, DONE} acc_spm_state_e;
//   - function win_base(ch, win) returning the word base of a window.
//  Sub-module acc_spm_seq
//   - Holds the FSM and the ch/idx counters; issues eng_req/eng_we/eng_addr.
//  Top level
//   - Owns the memory array, the core/engine port mux (core priority),
//     byte-enable writes and the operand output register.
// TESTING
//  1. Core write 0xDEADBEEF be=4'b0101 to byte addr 0x10, read back
//     -> rdata_o=0x00AD00EF one cycle later (mem previously 0).
//  2. Preload ch0 words=i, ch1 words=0x100+i; start_i; op_ready_i=1
//     -> 2*WIN_WORDS words in order; op_last_o on idx 255 of each channel;
//     then res_ready_o=1.
//  3. Send results 0xA000+i
//     -> done_o pulses once; core reads word 512+i return 0xA000+i; busy_o=0.
//  4. Hold en_i=1 for 10 cycles during OP_RD and RES
//     -> no engine access; res_ready_o=0; stream resumes with no loss or duplicates.
//  5. op_ready_i low 5 cycles in OP_OUT -> op_data_o and op_ch_o stable;
//     start_i pulse while busy -> ignored.
//  6. rst during RES at idx=100 -> outputs 0, IDLE; result words 0..99 retained;
//     a new start_i runs a full transfer.

Source files
------------

// File: rtl/acc_spm_pkg.sv
// acc_spm_pkg: engine state encoding and window layout helper shared by the scratchpad blocks
package acc_spm_pkg;
  typedef enum logic [2:0] {IDLE, OP_RD, OP_OUT, RES, DONE} acc_spm_state_e;
  function automatic int unsigned win_base(input int unsigned ch, input int unsigned win);
    return ch * win;
  endfunction
endpackage

// File: rtl/acc_spm_seq.sv
// acc_spm_seq: stream engine FSM with channel/index counters and memory request generation
module acc_spm_seq
  import acc_spm_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIN_WORDS = 256,
  parameter int MW = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       en,
  input  logic                       op_ready,
  input  logic                       res_valid,
  output logic [$clog2(NUM_CH):0]    ch,
  output logic                       busy,
  output logic                       done,
  output logic                       op_valid,
  output logic                       op_last,
  output logic                       res_ready,
  output logic                       eng_req,
  output logic                       eng_we,
  output logic [MW-1:0]              eng_addr
);
  localparam int CW = $clog2(NUM_CH) + 1;
  localparam int IW = $clog2(WIN_WORDS) + 1;
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIN_WORDS - 1);
  localparam logic [MW-1:0] RES_BASE = MW'(win_base(NUM_CH, WIN_WORDS));
  acc_spm_state_e state;
  acc_spm_state_e state_n;
  logic [CW-1:0] ch_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic res_hs;
  logic idx_end;
  assign idx_end = idx == IDX_LAST;
  assign op_valid = state == OP_OUT;
  assign op_last = op_valid && idx_end;
  assign res_ready = state == RES && !en;
  assign res_hs = res_ready && res_valid;
  assign done = state == DONE;
  assign eng_we = res_hs;
  assign eng_req = (state == OP_RD && !en) || res_hs;
  assign eng_addr = state == RES ? RES_BASE + MW'(idx)
                                 : MW'(win_base(32'(ch), WIN_WORDS)) + MW'(idx);
  always_comb begin
    state_n = state;
    ch_n = ch;
    idx_n = idx;
    case (state)
      IDLE: if (start) begin
        state_n = OP_RD;
        ch_n = '0;
        idx_n = '0;
      end
      OP_RD: state_n = en ? OP_RD : OP_OUT;
      OP_OUT: if (op_ready) begin
        state_n = (idx_end && ch == CH_LAST) ? RES : OP_RD;
        ch_n = (idx_end && ch != CH_LAST) ? ch + 1'b1 : ch;
        idx_n = idx_end ? '0 : idx + 1'b1;
      end
      RES: if (res_hs) begin
        state_n = idx_end ? DONE : RES;
        idx_n = idx_end ? '0 : idx + 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      idx <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      idx <= idx_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: rtl/acc_spm_ram.sv
// acc_spm_ram: core/accelerator shared scratchpad; core port wins, engine streams in idle cycles
module acc_spm_ram
  import acc_spm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS = 4096,
  parameter int NUM_CH = 2,
  parameter int WIN_WORDS = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [DATA_WIDTH-1:0]     op_data_o,
  output logic [$clog2(NUM_CH):0]   op_ch_o,
  output logic                      op_last_o,
  input  logic                      res_valid_i,
  output logic                      res_ready_o,
  input  logic [DATA_WIDTH-1:0]     res_data_i
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int WORDS = NUM_WORDS / NB;
  localparam int MW = $clog2(WORDS);
  localparam int CA = ADDR_WIDTH - OFF;
  if ((NUM_CH + 1) * WIN_WORDS > WORDS) begin : g_size_check
    $error("acc_spm_ram: operand and result windows exceed capacity");
  end
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [CA-1:0] caddr;
  logic [MW-1:0] cidx;
  logic core_ok;
  logic eng_req;
  logic eng_we;
  logic [MW-1:0] eng_addr;
  logic [$clog2(NUM_CH):0] ch;
  assign caddr = addr_i[ADDR_WIDTH-1:OFF];
  assign cidx = MW'(caddr);
  assign core_ok = 32'(caddr) < WORDS;
  acc_spm_seq #(
    .NUM_CH(NUM_CH),
    .WIN_WORDS(WIN_WORDS),
    .MW(MW)
  ) u_seq (
    .clk(clk),
    .rst(rst),
    .start(start_i),
    .en(en_i),
    .op_ready(op_ready_i),
    .res_valid(res_valid_i),
    .ch(ch),
    .busy(busy_o),
    .done(done_o),
    .op_valid(op_valid_o),
    .op_last(op_last_o),
    .res_ready(res_ready_o),
    .eng_req(eng_req),
    .eng_we(eng_we),
    .eng_addr(eng_addr)
  );
  assign op_ch_o = op_valid_o ? ch : '0;
  // engine writes only happen when the core is idle, so the two branches never collide
  always_ff @(posedge clk) begin
    if (en_i && we_i && core_ok) begin
      for (int b = 0; b < NB; b++)
        if (be_i[b]) mem[cidx][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end else if (eng_we && !rst) begin
      mem[eng_addr] <= res_data_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= '0;
      op_data_o <= '0;
    end else begin
      if (en_i) rdata_o <= core_ok ? mem[cidx] : '0;
      if (eng_req && !eng_we) op_data_o <= mem[eng_addr];
    end
  end
endmodule

// File: tb/tb_acc_spm_ram.sv
// tb_acc_spm_ram: scoreboard bench for the scratchpad core port and stream engine
module tb_acc_spm_ram;
  localparam int AW = 12, DW = 32, NB = 4, WIN = 256, NCH = 2, RB = NCH * WIN;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_i = 1'b0, we_i = 1'b0, start_i = 1'b0, op_ready_i = 1'b0, res_valid_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] wdata_i = '0, res_data_i = '0;
  logic [NB-1:0] be_i = '0;
  logic [DW-1:0] rdata_o, op_data_o;
  logic busy_o, done_o, op_valid_o, op_last_o, res_ready_o;
  logic [1:0] op_ch_o;
  int checks = 0, failures = 0, done_cnt = 0;
  logic [DW-1:0] model [1024];
  logic [34:0] op_q [$];
  logic [31:0] rd_q [$];
  logic rd_pend = 1'b0, held_v = 1'b0;
  logic [35:0] held;

  always #5 clk = ~clk;

  acc_spm_ram dut (
    .clk(clk), .rst(rst), .en_i(en_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .be_i(be_i), .rdata_o(rdata_o), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i), .op_data_o(op_data_o), .op_ch_o(op_ch_o),
    .op_last_o(op_last_o), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_data_i(res_data_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // core read pipeline, operand stream and hold-stability scoreboard
  always @(negedge clk) begin
    if (rst) begin
      rd_pend = 1'b0;
      held_v = 1'b0;
      rd_q.delete();
    end else begin
      if (rd_pend) check("rdata", rdata_o, rd_q.pop_front());
      rd_pend = en_i;
      if (en_i) begin
        rd_q.push_back(model[addr_i[11:2]]);
        if (we_i)
          for (int b = 0; b < NB; b++)
            if (be_i[b]) model[addr_i[11:2]][b*8 +: 8] = wdata_i[b*8 +: 8];
      end
      if (held_v) check("op_hold", {op_valid_o, op_ch_o, op_last_o, op_data_o}, held);
      if (op_valid_o && op_ready_i) begin
        check("op_avail", 64'(op_q.size() > 0), 1);
        if (op_q.size() > 0) check("op_word", {op_ch_o, op_last_o, op_data_o}, op_q.pop_front());
        held_v = 1'b0;
      end else begin
        held_v = op_valid_o;
        held = {op_valid_o, op_ch_o, op_last_o, op_data_o};
      end
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic core(input logic w, input int word, input logic [31:0] d, input logic [3:0] b);
    en_i = 1'b1; we_i = w; addr_i = AW'(word * 4); wdata_i = d; be_i = b;
    tick();
    en_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, busy_o, 0);
    check({p, "_done"}, done_o, 0);
    check({p, "_op_valid"}, op_valid_o, 0);
    check({p, "_res_ready"}, res_ready_o, 0);
    check({p, "_op_last"}, op_last_o, 0);
    check({p, "_op_ch"}, op_ch_o, 0);
    check({p, "_op_data"}, op_data_o, 0);
    check({p, "_rdata"}, rdata_o, 0);
  endtask

  task automatic run_ops(input bit stress);
    int n;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < WIN; i++)
        op_q.push_back({2'(c), i == WIN - 1, model[c*WIN + i]});
    op_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    if (stress) begin
      n = 0;
      while (op_q.size() > WIN + 10 && n < 2000) begin tick(); n++; end
      op_ready_i = 1'b0;
      n = 0;
      while (!op_valid_o && n < 10) begin tick(); n++; end
      check("t5_valid", op_valid_o, 1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (4) tick();
      check("t5_busy", busy_o, 1);
      op_ready_i = 1'b1;
      n = 0;
      while (op_valid_o && n < 10) begin tick(); n++; end
      en_i = 1'b1; we_i = 1'b0; addr_i = AW'(16);
      for (int k = 0; k < 10; k++) begin
        tick();
        check("t4_oprd_stall", op_valid_o, 0);
      end
      en_i = 1'b0;
    end
    n = 0;
    while (!(op_q.size() == 0 && res_ready_o) && n < 4000) begin tick(); n++; end
    check("ops_drained", op_q.size(), 0);
    check("res_ready", res_ready_o, 1);
  endtask

  task automatic run_res(input logic [31:0] base, input int cnt, input bit stress);
    int i = 0;
    int guard = 0;
    logic hs;
    bit stalled = 1'b0;
    while (i < cnt && guard < 4000) begin
      if (stress && i == 50 && !stalled) begin
        stalled = 1'b1;
        en_i = 1'b1; we_i = 1'b0; addr_i = AW'(16); res_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
          #1 check("t4_res_ready", res_ready_o, 0);
          tick();
        end
        en_i = 1'b0;
      end
      res_valid_i = 1'b1;
      res_data_i = base + 32'(i);
      #1 hs = res_ready_o;
      tick();
      if (hs) begin
        model[RB + i] = res_data_i;
        i++;
      end
      guard++;
    end
    res_valid_i = 1'b0;
    check("res_sent", i, cnt);
  endtask

  task automatic check_done(input string p);
    check({p, "_done_hi"}, done_o, 1);
    tick();
    check({p, "_done_lo"}, done_o, 0);
    check({p, "_busy_lo"}, busy_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    core(1'b1, 4, 32'h0, 4'hf);
    core(1'b1, 4, 32'hDEADBEEF, 4'b0101);
    core(1'b0, 4, 32'h0, 4'h0);
    check("t1_rdata", rdata_o, 32'h00AD00EF);
    for (int i = 0; i < WIN; i++) begin
      core(1'b1, i, 32'(i), 4'hf);
      core(1'b1, WIN + i, 32'h100 + 32'(i), 4'hf);
    end
    run_ops(1'b1);
    run_res(32'hA000, WIN, 1'b1);
    check_done("t3");
    check("t3_done_cnt", done_cnt, 1);
    for (int i = 0; i < WIN; i++) core(1'b0, RB + i, 32'h0, 4'h0);
    check("t3_last_word", rdata_o, 32'hA000 + WIN - 1);
    run_ops(1'b0);
    run_res(32'hB000, 100, 1'b0);
    check("t6_busy_before", busy_o, 1);
    rst = 1'b1;
    tick();
    check_idle("t6_rst");
    tick();
    rst = 1'b0;
    check("t6_no_done", done_cnt, 1);
    for (int i = 0; i < WIN; i++) core(1'b0, RB + i, 32'h0, 4'h0);
    core(1'b0, RB + 99, 32'h0, 4'h0);
    check("t6_w99", rdata_o, 32'hB000 + 99);
    core(1'b0, RB + 100, 32'h0, 4'h0);
    check("t6_w100", rdata_o, 32'hA000 + 100);
    run_ops(1'b0);
    run_res(32'hC000, WIN, 1'b0);
    check_done("t6");
    check("t6_done_cnt", done_cnt, 2);
    core(1'b0, RB + 7, 32'h0, 4'h0);
    check("t6_w7", rdata_o, 32'hC007);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
